// File: rtl/e203_exu_fpu_fmac_sched_pkg.sv
// Shared types and constants for the FMAC issue sequencer.
// Also supplies fallback widths when the core-wide width defines are absent.
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 4
`endif
`ifndef E203_DECINFO_FMAC_WIDTH
`define E203_DECINFO_FMAC_WIDTH 12
`endif

package e203_exu_fpu_fmac_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WBCK  = 3'd3,
    ST_DRAIN = 3'd4
  } sched_state_e;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam int          WDOG_CNT_W = 8;

endpackage

// File: rtl/e203_exu_fpu_fmac_sched_wdog.sv
// Watchdog counter for the FMAC sequencer: counts cycles while run is high,
// restarts on clear, and flags expiry on the TIMEOUT-th running cycle.
module e203_exu_fpu_fmac_sched_wdog
  import e203_exu_fpu_fmac_sched_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [WDOG_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of completed running cycles, so the current cycle is number cnt_q+1.
  assign expired = run & (cnt_q == WDOG_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/e203_exu_fpu_fmac_sched.sv
// Single-op issue sequencer between EXU dispatch and the FPU FMAC datapath, with flush draining.
// Optional watchdog compiled in with `define E203_FPU_SCHED_WDOG_EN.
module e203_exu_fpu_fmac_sched
  import e203_exu_fpu_fmac_sched_pkg::*;
#(
  parameter int ITAG_W  = `E203_ITAG_WIDTH,
  parameter int INFO_W  = `E203_DECINFO_FMAC_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [31:0]       disp_rs1,
  input  logic [31:0]       disp_rs2,
  input  logic [31:0]       disp_rs3,
  input  logic [INFO_W-1:0] disp_info,
  input  logic [ITAG_W-1:0] disp_itag,
  input  logic              flush_pulse,
  output logic              fmac_i_valid,
  input  logic              fmac_i_ready,
  output logic [31:0]       fmac_i_rs1,
  output logic [31:0]       fmac_i_rs2,
  output logic [31:0]       fmac_i_rs3,
  output logic [INFO_W-1:0] fmac_i_info,
  input  logic              fmac_o_valid,
  output logic              fmac_o_ready,
  input  logic [31:0]       fmac_o_wbck_wdat,
  output logic              wbck_valid,
  input  logic              wbck_ready,
  output logic [31:0]       wbck_wdat,
  output logic [ITAG_W-1:0] wbck_itag,
  output logic              wbck_err,
  output logic              busy
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and a flush pulse masks disp_ready and wbck_valid.

  sched_state_e      state_q, state_d;
  logic [31:0]       rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic [ITAG_W-1:0] itag_q, itag_d;
  logic [31:0]       wdat_q, wdat_d;
  logic              err_q, err_d;
  logic              wdog_expired;

`ifdef E203_FPU_SCHED_WDOG_EN
  e203_exu_fpu_fmac_sched_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .run     ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
    .expired (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rs3_d        = rs3_q;
    info_d       = info_q;
    itag_d       = itag_q;
    wdat_d       = wdat_q;
    err_d        = err_q;
    disp_ready   = 1'b0;
    fmac_i_valid = 1'b0;
    fmac_o_ready = 1'b0;
    wbck_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        disp_ready = ~flush_pulse;
        if (disp_valid && !flush_pulse) begin
          rs1_d   = disp_rs1;
          rs2_d   = disp_rs2;
          rs3_d   = disp_rs3;
          info_d  = disp_info;
          itag_d  = disp_itag;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fmac_i_valid = 1'b1;
        fmac_o_ready = 1'b1;
        // An accepted op cannot be aborted, so a flush after accept must drain its result.
        if (flush_pulse) begin
          state_d = (fmac_i_ready && !fmac_o_valid) ? ST_DRAIN : ST_IDLE;
        end else if (fmac_i_ready && fmac_o_valid) begin
          wdat_d  = fmac_o_wbck_wdat;
          err_d   = 1'b0;
          state_d = ST_WBCK;
        end else if (fmac_i_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        fmac_o_ready = 1'b1;
        if (flush_pulse) begin
          state_d = fmac_o_valid ? ST_IDLE : ST_DRAIN;
        end else if (fmac_o_valid) begin
          wdat_d  = fmac_o_wbck_wdat;
          err_d   = 1'b0;
          state_d = ST_WBCK;
        end else if (wdog_expired) begin
          wdat_d  = CANON_NAN;
          err_d   = 1'b1;
          state_d = ST_WBCK;
        end
      end
      ST_WBCK: begin
        wbck_valid = ~flush_pulse;
        if (flush_pulse || wbck_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        fmac_o_ready = 1'b1;
        if (fmac_o_valid || wdog_expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      info_q  <= '0;
      itag_q  <= '0;
      wdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      info_q  <= info_d;
      itag_q  <= itag_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
    end
  end

  assign fmac_i_rs1  = rs1_q;
  assign fmac_i_rs2  = rs2_q;
  assign fmac_i_rs3  = rs3_q;
  assign fmac_i_info = info_q;
  assign wbck_wdat   = wdat_q;
  assign wbck_itag   = itag_q;
  assign wbck_err    = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_e203_exu_fpu_fmac_sched.sv
// Self-checking bench for the FMAC issue sequencer: directed scenarios plus randomized
// single-op transactions scored against a transaction-level expected queue.
module tb_e203_exu_fpu_fmac_sched;

  localparam int ITAG_W  = 4;
  localparam int INFO_W  = 12;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] NAN_C = 32'h7FC0_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_valid, disp_ready;
  logic [31:0]       disp_rs1, disp_rs2, disp_rs3;
  logic [INFO_W-1:0] disp_info;
  logic [ITAG_W-1:0] disp_itag;
  logic              flush_pulse;
  logic              fmac_i_valid, fmac_i_ready;
  logic [31:0]       fmac_i_rs1, fmac_i_rs2, fmac_i_rs3;
  logic [INFO_W-1:0] fmac_i_info;
  logic              fmac_o_valid, fmac_o_ready;
  logic [31:0]       fmac_o_wbck_wdat;
  logic              wbck_valid, wbck_ready;
  logic [31:0]       wbck_wdat;
  logic [ITAG_W-1:0] wbck_itag;
  logic              wbck_err, busy;

  logic [ITAG_W+31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  e203_exu_fpu_fmac_sched #(
    .ITAG_W (ITAG_W), .INFO_W (INFO_W), .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk (clk), .rst (rst),
    .disp_valid (disp_valid), .disp_ready (disp_ready),
    .disp_rs1 (disp_rs1), .disp_rs2 (disp_rs2), .disp_rs3 (disp_rs3),
    .disp_info (disp_info), .disp_itag (disp_itag),
    .flush_pulse (flush_pulse),
    .fmac_i_valid (fmac_i_valid), .fmac_i_ready (fmac_i_ready),
    .fmac_i_rs1 (fmac_i_rs1), .fmac_i_rs2 (fmac_i_rs2), .fmac_i_rs3 (fmac_i_rs3),
    .fmac_i_info (fmac_i_info),
    .fmac_o_valid (fmac_o_valid), .fmac_o_ready (fmac_o_ready),
    .fmac_o_wbck_wdat (fmac_o_wbck_wdat),
    .wbck_valid (wbck_valid), .wbck_ready (wbck_ready),
    .wbck_wdat (wbck_wdat), .wbck_itag (wbck_itag), .wbck_err (wbck_err),
    .busy (busy)
  );

  // Clock / watchdog on the bench itself
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_disp_ready"}, disp_ready, 1);
    check_eq({pfx, "_fmac_i_valid"}, fmac_i_valid, 0);
    check_eq({pfx, "_fmac_o_ready"}, fmac_o_ready, 0);
    check_eq({pfx, "_wbck_valid"}, wbck_valid, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_info"}, fmac_i_info, 0);
    check_eq({pfx, "_rs1"}, fmac_i_rs1, 0);
    check_eq({pfx, "_wdat_itag_err"}, {wbck_itag, wbck_wdat, wbck_err}, 0);
  endtask

  // Dispatch one op in IDLE; returns at the ISSUE cycle with the issue checked.
  task automatic dispatch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [INFO_W-1:0] info, input logic [ITAG_W-1:0] itag);
    disp_valid = 1'b1;
    disp_rs1 = a; disp_rs2 = b; disp_rs3 = c; disp_info = info; disp_itag = itag;
    #1;
    check_eq("disp_ready_idle", disp_ready, 1);
    tick();
    disp_valid = 1'b0;
    disp_rs1 = $urandom(); disp_rs2 = $urandom(); disp_rs3 = $urandom();
    disp_info = INFO_W'($urandom()); disp_itag = ITAG_W'($urandom());
    #1;
    check_eq("issue_valid", fmac_i_valid, 1);
    check_eq("issue_o_ready", fmac_o_ready, 1);
    check_eq("issue_disp_ready", disp_ready, 0);
    check_eq("issue_ops", {fmac_i_rs1, fmac_i_rs2, fmac_i_rs3}, {a, b, c});
    check_eq("issue_info", fmac_i_info, info);
  endtask

  // Present the buffered result for stall+1 cycles, completing the handshake on the last.
  task automatic drain_wbck(input int stall, input logic exp_err);
    for (int i = 0; i <= stall; i++) begin
      wbck_ready = (i == stall);
      #1;
      check_eq("wbck_valid", wbck_valid, 1);
      check_eq("wbck_disp_ready", disp_ready, 0);
      check_eq("wbck_err", wbck_err, exp_err);
      if (exp_q.size() == 0) check_eq("sb_empty", 1, 0);
      else check_eq("wbck_data", {wbck_itag, wbck_wdat}, 64'(exp_q[0]));
      tick();
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    wbck_ready = 1'b0;
    #1;
    check_eq("post_wbck_busy", busy, 0);
    check_eq("post_wbck_disp_ready", disp_ready, 1);
    check_eq("post_wbck_valid", wbck_valid, 0);
  endtask

  // Complete op: FMAC accepts in ISSUE and answers lat cycles later (0 = same cycle).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [INFO_W-1:0] info, input logic [ITAG_W-1:0] itag,
                        input int lat, input int stall, input logic [31:0] res);
    dispatch(a, b, c, info, itag);
    fmac_i_ready = 1'b1;
    if (lat == 0) begin
      fmac_o_valid = 1'b1;
      fmac_o_wbck_wdat = res;
      exp_q.push_back({itag, res});
      tick();
    end else begin
      tick();
      fmac_i_ready = 1'b0;
      for (int i = 1; i < lat; i++) begin
        #1;
        check_eq("wait_i_valid", fmac_i_valid, 0);
        check_eq("wait_o_ready", fmac_o_ready, 1);
        check_eq("wait_wbck_valid", wbck_valid, 0);
        check_eq("wait_disp_ready", disp_ready, 0);
        check_eq("wait_info_stable", {fmac_i_info, fmac_i_rs1}, {info, a});
        tick();
      end
      #1;
      check_eq("resp_o_ready", fmac_o_ready, 1);
      fmac_o_valid = 1'b1;
      fmac_o_wbck_wdat = res;
      exp_q.push_back({itag, res});
      tick();
    end
    fmac_i_ready = 1'b0;
    fmac_o_valid = 1'b0;
    fmac_o_wbck_wdat = $urandom();
    drain_wbck(stall, 1'b0);
  endtask

  initial begin
    logic [INFO_W-1:0] held_info;
    int n;
    int bad;
    rst = 1'b1;
    disp_valid = 0; disp_rs1 = 0; disp_rs2 = 0; disp_rs3 = 0; disp_info = 0; disp_itag = 0;
    flush_pulse = 0; fmac_i_ready = 0; fmac_o_valid = 0; fmac_o_wbck_wdat = 0; wbck_ready = 0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_reset_vals("reset");

    // Zero-latency unit: writeback two cycles after dispatch
    run_op(32'h3F80_0000, 32'h4000_0000, 32'h0, 12'h011, 4'd5, 0, 0, 32'h4040_0000);

    // 10-cycle divider with writeback back-pressure for 3 cycles
    run_op(32'h4120_0000, 32'h4040_0000, 32'h0, 12'h240, 4'd9, 10, 3, 32'h4055_5555);

    // Flush while waiting: result is drained, never written back
    tick();
    dispatch(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 12'h0A5, 4'd3);
    fmac_i_ready = 1'b1;
    tick();
    fmac_i_ready = 1'b0;
    flush_pulse = 1'b1;
    #1;
    check_eq("flush_wait_o_ready", fmac_o_ready, 1);
    tick();
    flush_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("drain_busy", busy, 1);
      check_eq("drain_o_ready", fmac_o_ready, 1);
      check_eq("drain_wbck_valid", wbck_valid, 0);
      check_eq("drain_info", fmac_i_info, 12'h0A5);
      tick();
    end
    fmac_o_valid = 1'b1;
    fmac_o_wbck_wdat = 32'hDEAD_BEEF;
    #1;
    check_eq("drain_resp_o_ready", fmac_o_ready, 1);
    check_eq("drain_resp_wbck_valid", wbck_valid, 0);
    tick();
    fmac_o_valid = 1'b0;
    #1;
    check_eq("post_drain_busy", busy, 0);
    check_eq("post_drain_disp_ready", disp_ready, 1);
    check_eq("post_drain_wbck_valid", wbck_valid, 0);

    // Flush coincident with dispatch in IDLE: nothing is captured
    tick();
    disp_valid = 1'b1; flush_pulse = 1'b1;
    disp_rs1 = 32'hCAFE_0001; disp_info = 12'hFFF; disp_itag = 4'd7;
    #1;
    check_eq("flush_idle_disp_ready", disp_ready, 0);
    tick();
    disp_valid = 1'b0; flush_pulse = 1'b0;
    #1;
    check_eq("flush_idle_busy", busy, 0);
    check_eq("flush_idle_i_valid", fmac_i_valid, 0);
    check_eq("flush_idle_regs_held", {fmac_i_info, fmac_i_rs1}, {12'h0A5, 32'h1111_1111});

    // Flush coincident with wbck_ready: result dropped, no handshake
    tick();
    dispatch(32'h5, 32'h6, 32'h7, 12'h300, 4'd12);
    fmac_i_ready = 1'b1; fmac_o_valid = 1'b1; fmac_o_wbck_wdat = 32'h1234_5678;
    tick();
    fmac_i_ready = 1'b0; fmac_o_valid = 1'b0;
    wbck_ready = 1'b1; flush_pulse = 1'b1;
    #1;
    check_eq("flush_wbck_valid", wbck_valid, 0);
    tick();
    wbck_ready = 1'b0; flush_pulse = 1'b0;
    #1;
    check_eq("flush_wbck_busy", busy, 0);
    check_eq("flush_wbck_wbck_valid", wbck_valid, 0);
    check_eq("flush_wbck_info_held", fmac_i_info, 12'h300);

    // Flush in ISSUE: unaccepted op is simply dropped; accepted op goes to drain
    tick();
    dispatch(32'h8, 32'h9, 32'hA, 12'h00F, 4'd1);
    flush_pulse = 1'b1;
    tick();
    flush_pulse = 1'b0;
    #1;
    check_eq("flush_issue_noacc_busy", busy, 0);
    tick();
    dispatch(32'hB, 32'hC, 32'hD, 12'h0F0, 4'd2);
    flush_pulse = 1'b1; fmac_i_ready = 1'b1;
    tick();
    flush_pulse = 1'b0; fmac_i_ready = 1'b0;
    #1;
    check_eq("flush_issue_acc_busy", busy, 1);
    check_eq("flush_issue_acc_o_ready", fmac_o_ready, 1);
    check_eq("flush_issue_acc_i_valid", fmac_i_valid, 0);
    fmac_o_valid = 1'b1;
    tick();
    fmac_o_valid = 1'b0;
    #1;
    check_eq("flush_issue_acc_done", {busy, wbck_valid}, 2'b00);

    // Unresponsive FMAC unit
    tick();
    dispatch(32'hAAAA_0000, 32'hBBBB_0000, 32'h0, 12'h800, 4'd6);
    fmac_i_ready = 1'b1;
    tick();
    fmac_i_ready = 1'b0;
`ifdef E203_FPU_SCHED_WDOG_EN
    n = 0;
    #1;
    while (!wbck_valid && n < 200) begin
      tick();
      #1;
      n++;
    end
    check_eq("wdog_latency", n, TIMEOUT);
    exp_q.push_back({4'd6, NAN_C});
    drain_wbck(0, 1'b1);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!busy || wbck_valid) bad++;
      tick();
    end
    check_eq("nowdog_stays_busy", bad, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals("nowdog_rst");
`endif

    // Reset in WAIT returns everything to reset values next cycle
    tick();
    dispatch(32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h1, 12'h123, 4'd4);
    fmac_i_ready = 1'b1;
    tick();
    fmac_i_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals("rst_wait");

    // Randomized transactions scored against the expected queue
    for (int t = 0; t < 30; t++) begin
      held_info = INFO_W'($urandom());
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) begin
        tick();
        #1;
        check_eq("gap_disp_ready", disp_ready, 1);
      end
      tick();
      run_op($urandom(), $urandom(), $urandom(), held_info, ITAG_W'($urandom_range(0, 15)),
             $urandom_range(0, 6), $urandom_range(0, 3), $urandom());
    end

    check_eq("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/e203_exu_fpu_fmac_sched.md
# e203_exu_fpu_fmac_sched

Issue sequencer between the EXU dispatch point and the FPU FMAC datapath. It accepts one floating-point op at a time and registers its operands, decode info and itag. It holds them stable at the FMAC inputs until the result returns, buffers the result, and presents it with its itag to writeback. It also owns flush handling, because the FMAC sub-units cannot abort an accepted op.

## Interface
Parameters:
- ITAG_W, `E203_ITAG_WIDTH: itag width
- INFO_W, `E203_DECINFO_FMAC_WIDTH: FMAC decode-info width
- TIMEOUT, 64: watchdog limit in cycles (used only with the watchdog compiled in)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- disp_valid  in  1  dispatch request
- disp_ready  out  1  dispatch accept
- disp_rs1, disp_rs2, disp_rs3  in  32 each  operands
- disp_info  in  INFO_W  FMAC decode info
- disp_itag  in  ITAG_W  instruction tag
- flush_pulse  in  1  pipeline flush, one-cycle pulse
- fmac_i_valid  out  1  issue to FMAC
- fmac_i_ready  in  1  FMAC accept
- fmac_i_rs1, fmac_i_rs2, fmac_i_rs3  out  32 each  registered operands
- fmac_i_info  out  INFO_W  registered info, held stable through result
- fmac_o_valid  in  1  FMAC result valid
- fmac_o_ready  out  1  FMAC result accept
- fmac_o_wbck_wdat  in  32  FMAC result
- wbck_valid  out  1  writeback valid
- wbck_ready  in  1  writeback accept
- wbck_wdat  out  32  buffered result
- wbck_itag  out  ITAG_W  tag of result
- wbck_err  out  1  result error (watchdog only)
- busy  out  1  state != IDLE

## Operation
FSM states: IDLE, ISSUE, WAIT, WBCK, DRAIN. Flush has priority over every other event in the same cycle.

- IDLE:
  - disp_ready = ~flush_pulse.
  - On disp_valid & disp_ready: capture rs1–rs3, info and itag, then go to ISSUE.
- ISSUE:
  - fmac_i_valid = 1; fmac_o_ready = 1.
  - fmac_i_ready & fmac_o_valid in the same cycle (zero-latency unit): capture wdat, go to WBCK.
  - fmac_i_ready only: go to WAIT.
- WAIT:
  - fmac_o_ready = 1.
  - On fmac_o_valid: capture wdat, clear err, go to WBCK.
- WBCK:
  - wbck_valid = ~flush_pulse.
  - On wbck_ready: go to IDLE.
- DRAIN:
  - fmac_o_ready = 1.
  - On fmac_o_valid: discard the result, go to IDLE.

Flush handling:
- IDLE: dispatch refused.
- ISSUE without fmac_i_ready: go to IDLE.
- ISSUE with fmac_i_ready and no fmac_o_valid: go to DRAIN.
- ISSUE with fmac_i_ready and fmac_o_valid: go to IDLE.
- WAIT with fmac_o_valid: go to IDLE.
- WAIT without fmac_o_valid: go to DRAIN.
- WBCK: result dropped, go to IDLE.
- DRAIN: ignored; stay until the result is drained.

General rules:
- fmac_i_info and the operand registers hold their value from capture until the next dispatch. They are never cleared on return to IDLE, so the FMAC output mux stays selected through DRAIN.
- The fmac_i_info register resets to all-zero; no unit is selected.
- wbck_itag, wbck_wdat and wbck_err are stable for the whole of WBCK.

## Timing
- Reset values: state IDLE; all registers 0; disp_ready 1; fmac_i_valid 0; fmac_o_ready 0; wbck_valid 0; busy 0.
- Dispatch in cycle T gives fmac_i_valid at T+1.
- A zero-latency FMAC unit gives wbck_valid at T+2. An N-cycle unit gives wbck_valid one cycle after fmac_o_valid.
- The earliest next dispatch is the cycle after the wbck handshake. There is no overlap; at most one op is in flight.
- All outputs are decoded from the registered state, except disp_ready and wbck_valid, which are gated combinationally by flush_pulse.
- rst asserted mid-operation returns to IDLE next edge. The FMAC sub-units share the reset.

## Configuration
- E203_FPU_SCHED_WDOG_EN defined:
  - An 8-bit counter runs in WAIT and DRAIN and clears on every state entry.
  - When the count reaches TIMEOUT in WAIT: load wdat = 32'h7FC00000, set wbck_err = 1, go to WBCK.
  - When the count reaches TIMEOUT in DRAIN: go to IDLE.
  - fmac_o_valid arriving in the same cycle as the timeout wins.
- E203_FPU_SCHED_WDOG_EN undefined:
  - No counter.
  - wbck_err is tied to 0.
  - WAIT and DRAIN wait indefinitely.

## Structure
- Shared package/defines: state encodings (3-bit), canonical NaN constant 32'h7FC00000, watchdog counter width.
- One sub-module, e203_exu_fpu_fmac_sched_wdog:
  - Inputs: clk, rst, clear, run. Output: expired.
  - Instantiated only under E203_FPU_SCHED_WDOG_EN.
- The FSM and capture registers stay in the top module.

## Test plan
- Dispatch rs1=0x3F800000, rs2=0x40000000, itag=5, with a zero-latency model (fmac_i_ready=fmac_o_valid=1, wdat=0x40400000) -> wbck_valid at T+2, wbck_wdat=0x40400000, wbck_itag=5, wbck_err=0.
- 10-cycle divider model, wbck_ready held low 3 cycles -> fmac_i_info stable for all cycles; wbck_valid high 4 cycles; disp_ready=0 until the cycle after the handshake.
- flush_pulse in WAIT, result 4 cycles later -> DRAIN, result consumed (fmac_o_ready=1), wbck_valid never asserted, disp_ready=1 the cycle after.
- flush_pulse coincident with disp_valid in IDLE, and separately with wbck_ready in WBCK -> no capture; no writeback handshake; state IDLE.
- WDOG_EN, TIMEOUT=64, FMAC never responds -> wbck_valid 64 cycles after WAIT entry with wdat=0x7FC00000, err=1. Without the macro -> busy stays 1.
- rst asserted in WAIT -> next cycle all outputs at reset values.
